// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit per clock.
// Fixed latency with a start/busy/done handshake; the -2^(WIDTH-1) input saturates and flags ovf.
module twos_to_signmag_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tc_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sm_out,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-2:0]   mag_q, mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_one_q, seen_one_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sm_q, sm_d;
    logic               ovf_q, ovf_d;

    logic               cur_bit;
    logic               out_bit;
    logic [WIDTH-1:0]   mag_next;

    // Only the first WIDTH-1 output bits are stored; the last one is merged straight into the result.
    always_comb begin
        cur_bit  = shreg_q[0];
        out_bit  = cur_bit ^ (sign_q & seen_one_q);
        mag_next = {out_bit, mag_q};

        state_d    = state_q;
        shreg_d    = shreg_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        seen_one_d = seen_one_q;
        sign_d     = sign_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sm_d       = sm_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CONV;
                    shreg_d    = tc_in;
                    sign_d     = tc_in[WIDTH-1];
                    cnt_d      = '0;
                    seen_one_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CONV: begin
                shreg_d    = shreg_q >> 1;
                mag_d      = mag_next[WIDTH-1:1];
                seen_one_d = seen_one_q | cur_bit;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    ovf_d   = sign_q & mag_next[WIDTH-1];
                    sm_d    = (sign_q & mag_next[WIDTH-1]) ? '1
                                                           : {sign_q, mag_next[WIDTH-2:0]};
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            sign_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sm_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            seen_one_q <= seen_one_d;
            sign_q     <= sign_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sm_q       <= sm_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sm_out = sm_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/twos_to_signmag_serial.md
Name: twos_to_signmag_serial

Overview:
- Bit-serial converter from 32-bit two's complement to sign-magnitude form. It is the inverse partner of the datapath's two's-complement negation stage.
- The ALU/multiplier result path uses it to present signed results in sign-magnitude form for display and for the sign-magnitude divide unit.
- It processes one bit per clock, LSB first, using the rule "copy bits up to and including the first 1, then invert the rest".
- Start/done handshake; latency is constant for every input.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- tc_in  input  WIDTH  two's-complement operand; sampled on the accepting edge only
- busy  output  1  high from the accepting edge until the edge that returns to IDLE
- done  output  1  one-cycle pulse; result valid
- sm_out  output  WIDTH  result: {sign, magnitude[WIDTH-2:0]}
- ovf  output  1  high when the input magnitude is not representable (input = -2^(WIDTH-1))

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sm_out=0, ovf=0, shift register=0, bit counter=0, seen_one=0.
  - Reset mid-conversion aborts the conversion. No done pulse is produced.
- States: IDLE, CONV, FIN.
- IDLE:
  - On a clock edge with start=1, transition to CONV.
  - On that edge: load shift register with tc_in, latch sign=tc_in[WIDTH-1], clear counter, clear seen_one, set busy=1.
  - start=0: remain in IDLE.
- CONV, one edge per bit, LSB first, for exactly WIDTH edges:
  - Current bit b = shreg[0].
  - Output bit: if sign=0, out = b; if sign=1, out = b XOR seen_one.
  - seen_one |= b.
  - Output bit shifts into the magnitude register from the MSB end. Counter increments.
  - On the edge where the counter reaches WIDTH-1, the final bit is processed, the result is registered and the state moves to FIN.
- Result formation, using the WIDTH-bit magnitude mag:
  - ovf = sign AND mag[WIDTH-1].
  - sm_out = ovf ? {1'b1, all ones} (saturate to -(2^(WIDTH-1)-1)) : {sign, mag[WIDTH-2:0]}.
  - Zero input gives +0 (0x00000000). -0 is never produced.
- FIN: done=1 for exactly this cycle. On the next edge return to IDLE, busy=0.
- Timing: start accepted at edge E. done is high during the cycle following edge E+WIDTH. busy is high from E to E+WIDTH+1. This is 33-cycle latency at WIDTH=32, independent of the data.
- sm_out and ovf are registered outputs. They hold their value from FIN until the next FIN or reset; they do not change during a subsequent CONV.
- start in CONV or FIN is ignored; there is no queuing. start held high continuously causes back-to-back conversions, with re-acceptance at the IDLE edge one cycle after FIN.
- tc_in changes after the accepting edge have no effect.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-CONV (start with tc_in=0xFFFFFFFF, reset after 10 cycles) -> all outputs 0 immediately; no done pulse; IDLE after release.
- Positive: tc_in=0x0000_1234, start 1 cycle -> done exactly 32 cycles after the accepting edge; sm_out=0x0000_1234, ovf=0; busy high for 33 cycles.
- Negative: tc_in=0xFFFF_FFFF -> sm_out=0x8000_0001. tc_in=0xFFFF_EDCC -> sm_out=0x8000_1234. ovf=0 in both cases.
- Boundaries:
  - tc_in=0x0000_0000 -> sm_out=0x0, ovf=0.
  - tc_in=0x7FFF_FFFF -> sm_out=0x7FFF_FFFF.
  - tc_in=0x8000_0001 -> sm_out=0xFFFF_FFFF, ovf=0.
  - tc_in=0x8000_0000 -> sm_out=0xFFFF_FFFF, ovf=1.
- Handshake: pulse start again during CONV with different tc_in -> ignored, first result unchanged. Then hold start=1 across FIN -> second conversion accepted on the IDLE edge; sm_out holds the first result until the second done.
- Operand stability: change tc_in every cycle after acceptance of 0xFFFF_FFFE -> sm_out=0x8000_0002.
